// File: rtl/apb_event_pkg.sv
// Shared address map and decode types for the event sink and its upstream
// write master.
package apb_event_pkg;

    localparam logic [31:0] ADDR_EVT_A = 32'hABBA0000;
    localparam logic [31:0] ADDR_EVT_B = 32'hBAFF0000;
    localparam logic [31:0] ADDR_EVT_C = 32'hCAFE0000;
    localparam logic [31:0] ADDR_CTRL  = 32'hC1EA0000;

    typedef enum logic {IDLE, ACCESS} sink_state_t;

    typedef enum logic [2:0] {SEL_A, SEL_B, SEL_C, SEL_CTRL, SEL_NONE} sink_sel_t;

    // Exact 32-bit match against the register map.
    function automatic sink_sel_t decode_addr(input logic [31:0] addr);
        case (addr)
            ADDR_EVT_A: return SEL_A;
            ADDR_EVT_B: return SEL_B;
            ADDR_EVT_C: return SEL_C;
            ADDR_CTRL:  return SEL_CTRL;
            default:    return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/event_sink_acc.sv
// One saturating event accumulator with its sticky threshold flag.
module event_sink_acc #(
    parameter int          ACC_W     = 32,
    parameter logic [31:0] THRESHOLD = 32'd100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             add_en,
    input  logic [ACC_W-1:0] add_val,
    input  logic             clr,
    output logic [ACC_W-1:0] acc,
    output logic             flag
);

    // Sum pinned at all-ones on carry-out so the count never wraps.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    // Compare in 32 bits so any ACC_W works against the 32-bit threshold.
    function automatic logic at_threshold(input logic [ACC_W-1:0] v);
        logic [31:0] e;
        e = '0;
        e[ACC_W-1:0] = v;
        return e >= THRESHOLD;
    endfunction

    logic [ACC_W-1:0] sum;

    // Candidate post-add value for this cycle.
    always_comb sum = sat_add(acc, add_val);

    // Accumulate or clear; flag latches once the new value reaches threshold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= '0;
            flag <= 1'b0;
        end else if (clr) begin
            acc  <= '0;
            flag <= 1'b0;
        end else if (add_en) begin
            acc <= sum;
            if (at_threshold(sum)) flag <= 1'b1;
        end
    end

endmodule

// File: rtl/apb_event_sink.sv
// APB completer accumulating per-event counts with readback, wait states
// and a sticky threshold interrupt per channel.
// Optional: define APB_EVENT_SINK_SLVERR_EN to report decode errors on pslverr.
module apb_event_sink
    import apb_event_pkg::*;
#(
    parameter int          WAIT_CYCLES = 1,
    parameter int          ACC_W       = 32,
    parameter logic [31:0] THRESHOLD   = 32'd100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        apb_psel_i,
    input  logic        apb_penable_i,
    input  logic [31:0] apb_paddr_i,
    input  logic        apb_pwrite_i,
    input  logic [31:0] apb_pwdata_i,
    output logic        apb_pready_o,
    output logic [31:0] apb_prdata_o,
    output logic        apb_pslverr_o,
    output logic        irq_o
);

    localparam int WCW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    sink_state_t      state, state_nxt;
    logic [WCW-1:0]   wait_cnt, wait_nxt;
    logic             latch_en;
    logic [31:0]      lat_addr;
    logic             lat_write;
    logic [31:0]      lat_wdata;
    sink_sel_t        sel;
    logic             wr_commit;
    logic [2:0]       add_en;
    logic [2:0]       clr;
    logic [ACC_W-1:0] acc [3];
    logic [2:0]       flags;
    logic [31:0]      rd_val;

    // Control state: FSM state and remaining wait states.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next-state logic; pready is asserted only in ACCESS once waits expire.
    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        latch_en     = 1'b0;
        apb_pready_o = 1'b0;
        case (state)
            IDLE: begin
                if (apb_psel_i && !apb_penable_i) begin
                    latch_en  = 1'b1;
                    wait_nxt  = WCW'(WAIT_CYCLES);
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!apb_psel_i) begin
                    // Master abandoned the transfer: drop it silently.
                    state_nxt = IDLE;
                end else if (apb_penable_i) begin
                    if (wait_cnt == '0) begin
                        apb_pready_o = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        wait_nxt = wait_cnt - WCW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the setup-phase request; held for the whole access phase.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            lat_addr  <= apb_paddr_i;
            lat_write <= apb_pwrite_i;
            lat_wdata <= apb_pwdata_i;
        end
    end

    // Decode and commit strobes, valid only in the pready cycle.
    always_comb begin
        sel       = decode_addr(lat_addr);
        wr_commit = apb_pready_o && lat_write;
        add_en    = '0;
        clr       = '0;
        if (wr_commit) begin
            case (sel)
                SEL_A:    add_en = 3'b001;
                SEL_B:    add_en = 3'b010;
                SEL_C:    add_en = 3'b100;
                SEL_CTRL: clr    = lat_wdata[2:0];
                default:  ;
            endcase
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_chan
        event_sink_acc #(
            .ACC_W     (ACC_W),
            .THRESHOLD (THRESHOLD)
        ) u_acc (
            .clk     (clk),
            .reset_n (reset_n),
            .add_en  (add_en[i]),
            .add_val (lat_wdata[ACC_W-1:0]),
            .clr     (clr[i]),
            .acc     (acc[i]),
            .flag    (flags[i])
        );
    end

    // Read mux; zero outside the pready cycle and for writes.
    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_A:    rd_val[ACC_W-1:0] = acc[0];
            SEL_B:    rd_val[ACC_W-1:0] = acc[1];
            SEL_C:    rd_val[ACC_W-1:0] = acc[2];
            SEL_CTRL: rd_val[2:0]       = flags;
            default:  ;
        endcase
        apb_prdata_o = (apb_pready_o && !lat_write) ? rd_val : 32'd0;
    end

`ifdef APB_EVENT_SINK_SLVERR_EN
    // Decode error on unmapped addresses, plus misaligned control reads.
    always_comb apb_pslverr_o = apb_pready_o &&
                                ((sel == SEL_NONE) ||
                                 (!lat_write && sel == SEL_CTRL && lat_addr[1:0] != 2'b00));
`else
    // Decode errors are not reported in this build.
    always_comb apb_pslverr_o = 1'b0;
`endif

    // Flags are flops, so the OR follows a commit by exactly one cycle.
    always_comb irq_o = |flags;

endmodule

// File: tb/tb_apb_event_sink.sv
module tb_apb_event_sink;

    localparam int          WAIT    = 1;
    localparam int          ACC_W   = 8;
    localparam int          THR     = 10;
    localparam int          ACC_MAX = (1 << ACC_W) - 1;
    localparam logic [31:0] A_ADDR  = 32'hABBA0000;
    localparam logic [31:0] B_ADDR  = 32'hBAFF0000;
    localparam logic [31:0] C_ADDR  = 32'hCAFE0000;
    localparam logic [31:0] K_ADDR  = 32'hC1EA0000;
    localparam logic [31:0] U_ADDR  = 32'h12340000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        pready, pslverr, irq;
    logic [31:0] prdata;

    int n_checks = 0;
    int n_pass   = 0;

    int model_acc  [3];
    bit model_flag [3];

    always #5 clk = ~clk;

    apb_event_sink #(
        .WAIT_CYCLES (WAIT),
        .ACC_W       (ACC_W),
        .THRESHOLD   (32'(THR))
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .apb_psel_i    (psel),
        .apb_penable_i (penable),
        .apb_paddr_i   (paddr),
        .apb_pwrite_i  (pwrite),
        .apb_pwdata_i  (pwdata),
        .apb_pready_o  (pready),
        .apb_prdata_o  (prdata),
        .apb_pslverr_o (pslverr),
        .irq_o         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic int chan_of(input logic [31:0] a);
        if (a == A_ADDR) return 0;
        if (a == B_ADDR) return 1;
        if (a == C_ADDR) return 2;
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int ch = chan_of(a);
        if (ch >= 0) return 32'(model_acc[ch]);
        if (a == K_ADDR) return {29'd0, model_flag[2], model_flag[1], model_flag[0]};
        return 32'd0;
    endfunction

    function automatic bit model_err(input logic [31:0] a);
`ifdef APB_EVENT_SINK_SLVERR_EN
        return (chan_of(a) < 0) && (a != K_ADDR);
`else
        return (a == 32'hFFFFFFFF) && (a != 32'hFFFFFFFF);
`endif
    endfunction

    function automatic bit model_irq();
        return model_flag[0] | model_flag[1] | model_flag[2];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            model_acc[i]  = 0;
            model_flag[i] = 1'b0;
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        int ch = chan_of(a);
        int s;
        if (ch >= 0) begin
            s = model_acc[ch] + int'(d & 32'(ACC_MAX));
            if (s > ACC_MAX) s = ACC_MAX;
            model_acc[ch] = s;
            if (s >= THR) model_flag[ch] = 1'b1;
        end else if (a == K_ADDR) begin
            for (int i = 0; i < 3; i++)
                if (d[i]) begin
                    model_acc[i]  = 0;
                    model_flag[i] = 1'b0;
                end
        end
    endtask

    // One APB transfer; reports data/err/irq seen in the pready cycle and
    // the number of access cycles until pready.
    task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rdata, output bit err, output bit irq_rdy,
                            output int lat, output bit ok);
        rdata = '0; err = 1'b0; irq_rdy = 1'b0; lat = 0; ok = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (16) begin
            lat++;
            @(negedge clk);
            if (pready) begin
                rdata = prdata; err = pslverr; irq_rdy = irq; ok = 1'b1;
                break;
            end
            chk("prdata_wait", prdata, 32'd0);
            chk("pslverr_wait", {31'd0, pslverr}, 32'd0);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_op(input string tag, input bit wr, input logic [31:0] a,
                         input logic [31:0] d);
        logic [31:0] rdata;
        bit err, irq_rdy, ok, irq_before;
        int lat;
        irq_before = model_irq();
        apb_xfer(wr, a, d, rdata, err, irq_rdy, lat, ok);
        chk({tag, "_done"}, {31'd0, ok}, 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(WAIT + 1));
        chk({tag, "_err"}, {31'd0, err}, {31'd0, model_err(a)});
        chk({tag, "_irq_pre"}, {31'd0, irq_rdy}, {31'd0, irq_before});
        if (!wr) chk({tag, "_rd"}, rdata, model_read(a));
        else model_write(a, d);
        chk({tag, "_irq"}, {31'd0, irq}, {31'd0, model_irq()});
    endtask

    initial begin
        logic [31:0] a, d;
        int r;
        reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        model_reset();
        #1;
        chk("rst_pready", {31'd0, pready}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        do_op("wr_a3", 1, A_ADDR, 3);
        do_op("rd_a", 0, A_ADDR, 0);
        do_op("wr_c5", 1, C_ADDR, 5);
        do_op("wr_c7", 1, C_ADDR, 7);
        do_op("rd_c", 0, C_ADDR, 0);
        do_op("rd_b0", 0, B_ADDR, 0);
        do_op("clr_c", 1, K_ADDR, 32'h4);
        do_op("wr_b6", 1, B_ADDR, 6);
        do_op("wr_b4", 1, B_ADDR, 4);
        do_op("rd_ctrl", 0, K_ADDR, 0);
        do_op("clr_b", 1, K_ADDR, 32'h2);
        do_op("rd_b", 0, B_ADDR, 0);
        do_op("wr_a250", 1, A_ADDR, 250);
        do_op("wr_a10", 1, A_ADDR, 10);
        do_op("rd_a_sat", 0, A_ADDR, 0);
        do_op("clr_a", 1, K_ADDR, 32'h1);
        do_op("wr_c12", 1, C_ADDR, 12);
        do_op("clr_c2", 1, K_ADDR, 32'h4);
        do_op("wr_c0", 1, C_ADDR, 0);
        do_op("rd_ctrl2", 0, K_ADDR, 0);
        do_op("wr_unm", 1, U_ADDR, 77);
        do_op("rd_unm", 0, U_ADDR, 0);
        do_op("rd_a2", 0, A_ADDR, 0);

        // Master drops psel after the first access cycle: nothing commits.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = B_ADDR; pwrite = 1'b1; pwdata = 50;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("abort_pready", {31'd0, pready}, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        do_op("rd_b_abort", 0, B_ADDR, 0);

        // Reset in the pready cycle of a write loses the transfer.
        do_op("wr_b3", 1, B_ADDR, 3);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = A_ADDR; pwrite = 1'b1; pwdata = 9;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        chk("mid_pready_hi", {31'd0, pready}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_pready_lo", {31'd0, pready}, 32'd0);
        chk("mid_irq", {31'd0, irq}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        model_reset();
        @(posedge clk); #1 reset_n = 1'b1;
        do_op("rd_a_rst", 0, A_ADDR, 0);
        do_op("rd_b_rst", 0, B_ADDR, 0);
        do_op("rd_ctrl_rst", 0, K_ADDR, 0);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0:       a = A_ADDR;
                1:       a = B_ADDR;
                default: a = C_ADDR;
            endcase
            d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
            if (r <= 3) do_op("rnd_wr", 1, a, d);
            else if (r <= 6) do_op("rnd_rd", 0, a, 0);
            else if (r == 7) do_op("rnd_clr", 1, K_ADDR, 32'($urandom_range(0, 7)));
            else if (r == 8) begin
                a = $urandom;
                if (chan_of(a) >= 0 || a == K_ADDR) a = U_ADDR;
                do_op("rnd_unm", 1'($urandom_range(0, 1)), a, $urandom);
            end else do_op("rnd_ctrl", 0, K_ADDR, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
